// File: rtl/vector_checker.sv
// vector_checker: compares a stream of sampled words against a preloaded
// table of expected values with per-bit care masks, counting mismatches and
// capturing the first failing vector.
//
// Ports:
//   clk            rising-edge clock
//   reset          synchronous active-low reset
//   load_we        expected-vector write enable (honoured only in IDLE)
//   load_addr      expected-vector write address
//   load_exp       expected value to store
//   load_care      care mask to store (1 = compare bit)
//   start          begin a check run (honoured only in IDLE)
//   num_vec        vectors in the run, sampled on start, clamped to 32
//   sample         word under check
//   sample_valid   sample is checked this cycle
//   busy           high while a run is in progress
//   done           one-cycle pulse at end of run
//   pass           last completed run had no mismatches
//   err_count      mismatch count of current/last run
//   first_err_idx  index of first mismatching vector
//   first_err_data sample value at first mismatch
module vector_checker #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned DEPTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_we,
  input  logic [4:0]       load_addr,
  input  logic [WIDTH-1:0] load_exp,
  input  logic [WIDTH-1:0] load_care,
  input  logic             start,
  input  logic [5:0]       num_vec,
  input  logic [WIDTH-1:0] sample,
  input  logic             sample_valid,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [5:0]       err_count,
  output logic [4:0]       first_err_idx,
  output logic [WIDTH-1:0] first_err_data
);

  localparam int unsigned AW = 5;
  localparam int unsigned NW = 6;
  localparam logic [NW-1:0] MAX_VEC = NW'(32);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  // Expected table: {care, exp} per entry; not touched by reset.
  logic [2*WIDTH-1:0] mem [DEPTH];

  logic [1:0]       state, state_d;
  logic [AW-1:0]    idx, idx_d;
  logic [NW-1:0]    num_q, num_d;
  logic [NW-1:0]    err_d;
  logic [AW-1:0]    fidx_d;
  logic [WIDTH-1:0] fdata_d;
  logic             pass_d;
  logic             busy_d;
  logic             done_d;
  logic             mem_we_c;
  logic [NW-1:0]    num_eff_c;
  logic [WIDTH-1:0] exp_c;
  logic [WIDTH-1:0] care_c;
  logic             mismatch_c;
  logic             last_c;

  // Zero-latency lookup of the entry for the vector currently under check.
  assign {care_c, exp_c} = mem[idx];
  assign mismatch_c      = |((sample ^ exp_c) & care_c);
  assign last_c          = (NW'(idx) == (num_q - NW'(1)));
  assign num_eff_c       = (num_vec > MAX_VEC) ? MAX_VEC : num_vec;

  // Table write port; a write in the same cycle as start still lands.
  always_ff @(posedge clk) begin
    if (mem_we_c) begin
      mem[load_addr] <= {load_care, load_exp};
    end
  end

  // State and result registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state          <= IDLE;
      idx            <= '0;
      num_q          <= '0;
      err_count      <= '0;
      first_err_idx  <= '0;
      first_err_data <= '0;
      pass           <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
    end else begin
      state          <= state_d;
      idx            <= idx_d;
      num_q          <= num_d;
      err_count      <= err_d;
      first_err_idx  <= fidx_d;
      first_err_data <= fdata_d;
      pass           <= pass_d;
      busy           <= busy_d;
      done           <= done_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d  = state;
    idx_d    = idx;
    num_d    = num_q;
    err_d    = err_count;
    fidx_d   = first_err_idx;
    fdata_d  = first_err_data;
    pass_d   = pass;
    mem_we_c = 1'b0;

    case (state)
      IDLE: begin
        mem_we_c = load_we && reset;
        if (start) begin
          idx_d   = '0;
          num_d   = num_eff_c;
          err_d   = '0;
          fidx_d  = '0;
          fdata_d = '0;
          pass_d  = 1'b0;
          state_d = (num_eff_c == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (sample_valid) begin
          if (mismatch_c) begin
            if (err_count == '0) begin
              fidx_d  = idx;
              fdata_d = sample;
            end
            if (err_count != MAX_VEC) begin
              err_d = err_count + NW'(1);
            end
          end
          idx_d = idx + AW'(1);
          if (last_c) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        pass_d  = (err_count == '0);
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // busy/done are registered decodes of the next state so they align with it.
  always_comb begin
    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

endmodule

// File: tb/tb_vector_checker.sv
module tb_vector_checker;

  logic       clk;
  logic       reset;
  logic       load_we;
  logic [4:0] load_addr;
  logic [3:0] load_exp;
  logic [3:0] load_care;
  logic       start;
  logic [5:0] num_vec;
  logic [3:0] sample;
  logic       sample_valid;
  logic       busy;
  logic       done;
  logic       pass;
  logic [5:0] err_count;
  logic [4:0] first_err_idx;
  logic [3:0] first_err_data;

  vector_checker #(.WIDTH(4), .DEPTH(32)) dut (
    .clk            (clk),
    .reset          (reset),
    .load_we        (load_we),
    .load_addr      (load_addr),
    .load_exp       (load_exp),
    .load_care      (load_care),
    .start          (start),
    .num_vec        (num_vec),
    .sample         (sample),
    .sample_valid   (sample_valid),
    .busy           (busy),
    .done           (done),
    .pass           (pass),
    .err_count      (err_count),
    .first_err_idx  (first_err_idx),
    .first_err_data (first_err_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [5:0] err;
    logic [4:0] fidx;
    logic [3:0] fdata;
    logic       pass;
  } exp_t;

  exp_t       expq [$];
  logic [3:0] sq [$];
  logic       vq [$];
  int         total = 0;
  int         bad   = 0;
  int         dones = 0;
  int         runs  = 0;
  logic       pend_pass = 1'b0;
  logic       pass_want = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, want);
    end
  endtask

  // Monitor: on each done pulse pop the scoreboard and check results.
  always @(negedge clk) begin
    if (pend_pass) begin
      chk("pass", 32'(pass), 32'(pass_want));
      pend_pass = 1'b0;
    end
    if (reset && done) begin
      dones++;
      if (expq.size() == 0) begin
        chk("unexpected_done", 32'(done), 32'(0));
      end else begin
        exp_t e;
        e = expq.pop_front();
        chk("err_count", 32'(err_count), 32'(e.err));
        chk("first_err_idx", 32'(first_err_idx), 32'(e.fidx));
        chk("first_err_data", 32'(first_err_data), 32'(e.fdata));
        chk("busy_in_done", 32'(busy), 32'(0));
        pend_pass = 1'b1;
        pass_want = e.pass;
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic load(input logic [4:0] a, input logic [3:0] e, input logic [3:0] c);
    load_we = 1'b1; load_addr = a; load_exp = e; load_care = c;
    @(posedge clk); #1;
    load_we = 1'b0;
  endtask

  // Start a run of nv vectors using sq/vq as per-cycle sample/valid.
  task automatic run_vec(input logic [5:0] nv, input exp_t e);
    expq.push_back(e);
    runs++;
    start = 1'b1; num_vec = nv;
    @(posedge clk); #1;
    start = 1'b0; load_we = 1'b0;
    if (sq.size() == 0) begin
      @(negedge clk);
      chk("zero_done", 32'(done), 32'(1));
      chk("zero_busy", 32'(busy), 32'(0));
      @(posedge clk); #1;
    end else begin
      for (int i = 0; i < sq.size(); i++) begin
        sample = sq[i]; sample_valid = vq[i];
        @(negedge clk);
        chk("busy_in_run", 32'(busy), 32'(1));
        chk("no_early_done", 32'(done), 32'(0));
        @(posedge clk); #1;
      end
      sample_valid = 1'b0;
      @(negedge clk);
      chk("done_latency", 32'(done), 32'(1));
      @(posedge clk); #1;
    end
    idle(2);
  endtask

  initial begin
    reset = 1'b0; load_we = 1'b0; load_addr = '0; load_exp = '0; load_care = '0;
    start = 1'b0; num_vec = '0; sample = '0; sample_valid = 1'b0;
    idle(2);
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_done", 32'(done), 32'(0));
    chk("rst_pass", 32'(pass), 32'(0));
    chk("rst_err", 32'(err_count), 32'(0));
    @(posedge clk); #1;
    reset = 1'b1;

    load(5'd0, 4'h3, 4'hF);
    load(5'd1, 4'h5, 4'hF);
    load(5'd2, 4'hA, 4'hF);
    load(5'd3, 4'hF, 4'hF);

    // All match; a write attempted during RUN must be dropped.
    expq.push_back('{err: 6'd0, fidx: 5'd0, fdata: 4'h0, pass: 1'b1});
    runs++;
    start = 1'b1; num_vec = 6'd4;
    @(posedge clk); #1;
    start = 1'b0;
    sample = 4'h3; sample_valid = 1'b1;
    load_we = 1'b1; load_addr = 5'd1; load_exp = 4'h4; load_care = 4'hF;
    @(posedge clk); #1;
    load_we = 1'b0;
    sample = 4'h5; @(posedge clk); #1;
    sample = 4'hA; @(posedge clk); #1;
    sample = 4'hF; @(posedge clk); #1;
    sample_valid = 1'b0;
    @(negedge clk);
    chk("done_latency_a", 32'(done), 32'(1));
    @(posedge clk); #1;
    idle(2);

    // Two mismatches, first at index 1.
    sq = '{4'h3, 4'h4, 4'hA, 4'h0}; vq = '{1'b1, 1'b1, 1'b1, 1'b1};
    run_vec(6'd4, '{err: 6'd2, fidx: 5'd1, fdata: 4'h4, pass: 1'b0});

    // Don't-care bits are ignored.
    load(5'd0, 4'h8, 4'h8);
    sq = '{4'h9}; vq = '{1'b1};
    run_vec(6'd1, '{err: 6'd0, fidx: 5'd0, fdata: 4'h0, pass: 1'b1});

    // Empty run goes straight to DONE.
    sq = {}; vq = {};
    run_vec(6'd0, '{err: 6'd0, fidx: 5'd0, fdata: 4'h0, pass: 1'b1});

    // num_vec above 32 clamps to 32 checks; last vector mismatches.
    for (int i = 0; i < 32; i++) load(5'(i), 4'(i), 4'hF);
    sq = {}; vq = {};
    for (int i = 0; i < 32; i++) begin
      sq.push_back((i == 31) ? 4'h0 : 4'(i));
      vq.push_back(1'b1);
    end
    run_vec(6'd40, '{err: 6'd1, fidx: 5'd31, fdata: 4'h0, pass: 1'b0});

    // Valid gaps; start coincides with a write that must land (entry 3).
    load(5'd0, 4'h3, 4'hF);
    load(5'd1, 4'h5, 4'hF);
    load(5'd2, 4'hA, 4'hF);
    load_we = 1'b1; load_addr = 5'd3; load_exp = 4'hF; load_care = 4'hF;
    sq = '{4'h3, 4'hE, 4'hE, 4'h5, 4'h0, 4'hE, 4'hF};
    vq = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    run_vec(6'd4, '{err: 6'd1, fidx: 5'd2, fdata: 4'h0, pass: 1'b0});

    // Reset mid-run beats a simultaneous start and write.
    start = 1'b1; num_vec = 6'd4;
    @(posedge clk); #1;
    start = 1'b0;
    sample = 4'h3; sample_valid = 1'b1; @(posedge clk); #1;
    sample = 4'h4; @(posedge clk); #1;
    sample_valid = 1'b0;
    @(negedge clk);
    chk("pre_rst_err", 32'(err_count), 32'(1));
    @(posedge clk); #1;
    reset = 1'b0; start = 1'b1; num_vec = 6'd4;
    load_we = 1'b1; load_addr = 5'd0; load_exp = 4'h0; load_care = 4'hF;
    @(posedge clk); #1;
    reset = 1'b1; start = 1'b0; load_we = 1'b0;
    @(negedge clk);
    chk("mid_rst_busy", 32'(busy), 32'(0));
    chk("mid_rst_done", 32'(done), 32'(0));
    chk("mid_rst_pass", 32'(pass), 32'(0));
    chk("mid_rst_err", 32'(err_count), 32'(0));
    chk("mid_rst_fidx", 32'(first_err_idx), 32'(0));
    chk("mid_rst_fdata", 32'(first_err_data), 32'(0));
    @(posedge clk); #1;
    idle(1);

    // Memory survives reset.
    sq = '{4'h3, 4'h5, 4'hA, 4'hF}; vq = '{1'b1, 1'b1, 1'b1, 1'b1};
    run_vec(6'd4, '{err: 6'd0, fidx: 5'd0, fdata: 4'h0, pass: 1'b1});

    idle(2);
    chk("sb_drain", 32'(expq.size()), 32'(0));
    chk("done_count", 32'(dones), 32'(runs));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vector_checker.md
VECTOR_CHECKER -- requirements
Module: vector_checker

Interface
REQ-001 Parameter WIDTH, default 4, is the width of the checked data word.
REQ-002 Parameter DEPTH, default 32, is the number of expected-vector entries; address width is 5 bits.
REQ-003 The block SHALL have one clock; reset is synchronous and active-low.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 reset  input  1  synchronous, active-low reset.
REQ-006 load_we  input  1  write enable for the expected-vector memory.
REQ-007 load_addr  input  5  expected-vector write address.
REQ-008 load_exp  input  WIDTH  expected value to store.
REQ-009 load_care  input  WIDTH  care mask to store; 1 = bit compared, 0 = don't-care.
REQ-010 start  input  1  begin a check run.
REQ-011 num_vec  input  6  number of vectors in the run (0..32), sampled on start.
REQ-012 sample  input  WIDTH  DUT output word under check (e.g. register A output).
REQ-013 sample_valid  input  1  sample is to be checked this cycle.
REQ-014 busy  output  1  high while in RUN.
REQ-015 done  output  1  one-cycle pulse at end of run.
REQ-016 pass  output  1  last completed run had zero mismatches.
REQ-017 err_count  output  6  mismatch count of current/last run.
REQ-018 first_err_idx  output  5  index of first mismatching vector.
REQ-019 first_err_data  output  WIDTH  sample value at first mismatch.

Function
REQ-020 FSM states: IDLE, RUN, DONE.
REQ-021 Memory writes SHALL occur only in IDLE: on load_we, mem[load_addr] <= {load_care, load_exp}; load_we in RUN/DONE is ignored.
REQ-022 In IDLE, start with num_vec in 1..32 SHALL go to RUN; idx, err_count, first_err_idx, first_err_data and pass are cleared.
REQ-023 In IDLE, start with num_vec = 0 SHALL go to DONE with err_count = 0; pass is set in DONE.
REQ-024 In IDLE, start with num_vec > 32 SHALL be treated as 32.
REQ-025 If start and load_we are asserted in the same IDLE cycle, the write SHALL complete and the run SHALL start.
REQ-026 In RUN, each cycle with sample_valid = 1 SHALL compare: mismatch = |((sample ^ exp[idx]) & care[idx]).
REQ-027 The expected entry SHALL be read combinationally at idx, with zero added latency.
REQ-028 On a mismatch, err_count increments; if err_count was 0, capture first_err_idx = idx and first_err_data = sample.
REQ-029 After each checked sample, idx increments; on the sample with idx = num_vec-1, the next state is DONE.
REQ-030 sample_valid = 0 in RUN SHALL hold all state.
REQ-031 start in RUN or DONE SHALL be ignored.
REQ-032 DONE SHALL last exactly one cycle: done = 1, pass <= (err_count == 0), then go to IDLE.
REQ-033 done SHALL assert in the cycle after the last sample is accepted.
REQ-034 pass, err_count, first_err_idx and first_err_data SHALL hold their values in IDLE until the next accepted start.
REQ-035 busy SHALL be 1 exactly in RUN.
REQ-036 err_count SHALL not wrap; its maximum is 32, which fits in 6 bits.

Reset
REQ-037 When reset = 0 at a rising edge, the state SHALL go to IDLE and busy, done, pass, err_count, first_err_idx, first_err_data and idx SHALL be 0, regardless of state (including mid-RUN).
REQ-038 Memory contents SHALL NOT be cleared by reset.
REQ-039 Reset SHALL take priority over start and load_we in the same cycle.

Verification
REQ-040 Load mem[0..3] = exp {3,5,A,F}, care F; start with num_vec = 4; apply samples 3,5,A,F on consecutive cycles -> done pulses 1 cycle after F, pass = 1, err_count = 0.
REQ-041 Same load, samples 3,4,A,0 -> err_count = 2, first_err_idx = 1, first_err_data = 4, pass = 0.
REQ-042 mem[0] = exp 8, care 8; sample 9 -> no mismatch, pass = 1 with num_vec = 1.
REQ-043 start with num_vec = 0 -> done the next cycle, pass = 1, busy never asserted.
REQ-044 num_vec = 4 with sample_valid gaps (1,0,0,1,1,0,1) -> exactly 4 checks, done after the 4th valid sample.
REQ-045 reset = 0 mid-RUN after 2 samples -> all outputs 0 next cycle; a new run with the same memory contents -> correct results.
